// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store access controller.
//   - RV32I funct3 width codes used on the request and memory sides
//   - controller state encoding
//   - decode helpers: alignment and funct3 legality
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_LO   = 3'd1,
        S_LD_HI   = 3'd2,
        S_ST_BYTE = 3'd3,
        S_RESP    = 3'd4
    } lsu_state_t;

    // Bytes never misalign; halfwords need addr[0]=0, words addr[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] off);
        case (funct3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        if (we)
            return funct3 inside {F3_B, F3_H, F3_W};
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/lsu_access_ctrl_load_merge.sv
// Combines the two aligned words fetched for a misaligned load.
//   lo, hi  : words at the aligned base address and base+4
//   offset  : original addr[1:0]
//   funct3  : original load width code (lh/lhu/lw)
//   data    : extracted value, sign-extended for lh, zero-extended for lhu
module lsu_load_merge
    import lsu_pkg::*;
(
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = 32'({hi, lo} >> {offset, 3'b000});
        case (funct3)
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data = {16'h0000, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_access_ctrl.sv
// Load/store access controller between execute and byte-addressed memory.
// Takes one request at a time (req_valid/req_ready), issues one or more
// aligned memory operations, and returns load data or an error on
// resp_valid/resp_ready.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_*             request: we, funct3, byte addr, store data
//   resp_*            response: extended load data, error flag
//   mem_*             memory op (write strobe, width, addr, wdata) and
//                     combinational read data
//
// Build option: define LSU_MISALIGN_SPLIT_EN to split misaligned
// lh/lhu/lw into two word reads and sh/sw into byte writes. Without it any
// misaligned access answers with resp_err=1 and issues no memory op.
module lsu_access_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    // Load vs store is carried by the state path, so req_we is not stored.
    lsu_state_t            state_q, state_d;
    logic [2:0]            f3_q, f3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  req_mis;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic                  split_q, split_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] merged;
    logic [1:0]            cnt_last;

    lsu_load_merge u_merge (
        .lo     (lo_q),
        .hi     (mem_rd_data),
        .offset (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (merged)
    );

    // Only sh/sw are ever split on the store side (2 or 4 byte ops).
    assign cnt_last = (f3_q == F3_H) ? 2'd1 : 2'd3;
`endif

    assign word_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign req_mis    = is_misaligned(req_funct3, req_addr[1:0]);
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    always_comb begin
        state_d      = state_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_d      = split_q;
        cnt_d        = cnt_q;
        lo_d         = lo_q;
`endif
        mem_wr_en    = 1'b0;
        mem_funct3   = 3'b000;
        mem_addr     = '0;
        mem_wr_data  = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    f3_d         = req_funct3;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    split_d      = req_mis;
                    cnt_d        = 2'd0;
`endif
                    if (!f3_legal(req_we, req_funct3)) begin
                        resp_err_d = 1'b1;
                        state_d    = S_RESP;
                    end
`ifndef LSU_MISALIGN_SPLIT_EN
                    else if (req_mis) begin
                        resp_err_d = 1'b1;
                        state_d    = S_RESP;
                    end
`endif
                    else begin
                        state_d = req_we ? S_ST_BYTE : S_LD_LO;
                    end
                end
            end

            S_LD_LO: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (split_q) begin
                    mem_funct3 = F3_W;
                    mem_addr   = word_addr;
                    lo_d       = mem_rd_data;
                    state_d    = S_LD_HI;
                end else
`endif
                begin
                    // Memory already extracts and extends aligned loads.
                    mem_funct3   = f3_q;
                    mem_addr     = addr_q;
                    resp_rdata_d = mem_rd_data;
                    state_d      = S_RESP;
                end
            end

`ifdef LSU_MISALIGN_SPLIT_EN
            S_LD_HI: begin
                mem_funct3   = F3_W;
                mem_addr     = word_addr + ADDR_WIDTH'(4);
                resp_rdata_d = merged;
                state_d      = S_RESP;
            end
`endif

            S_ST_BYTE: begin
                mem_wr_en = 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
                if (split_q) begin
                    mem_funct3  = F3_B;
                    mem_addr    = addr_q + ADDR_WIDTH'(cnt_q);
                    mem_wr_data = {{(DATA_WIDTH-8){1'b0}}, wdata_q[{cnt_q, 3'b000} +: 8]};
                    cnt_d       = cnt_q + 2'd1;
                    if (cnt_q == cnt_last)
                        state_d = S_RESP;
                end else
`endif
                begin
                    mem_funct3  = f3_q;
                    mem_addr    = addr_q;
                    mem_wr_data = wdata_q;
                    state_d     = S_RESP;
                end
            end

            S_RESP: begin
                if (resp_ready)
                    state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            f3_q         <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q      <= 1'b0;
            cnt_q        <= 2'd0;
            lo_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q      <= split_d;
            cnt_q        <= cnt_d;
            lo_q         <= lo_d;
`endif
        end
    end

endmodule
